apb_uart_if: RTL and testbench
==============================

Name: apb_uart_if

Overview:
APB3 slave that connects the RV32 CPU bus to the UART core's FIFO-side port. It decodes four word registers: status, TX data, RX data and control. It converts APB transfers into single-cycle push/pop strobes toward the core. It also keeps a saturating TX-drop counter and generates a level RX interrupt.

Parameters:
ADDR_W, 4, PADDR width; only PADDR[3:2] is decoded, PADDR[1:0] is ignored.
DATA_W, 32, PWDATA/PRDATA width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
PADDR  in  ADDR_W  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  1 = write
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data; valid when PREADY=1
PREADY  out  1  transfer complete
PSLVERR  out  1  error response; valid with PREADY
o_tx_pushdata  out  8  byte toward the core TX FIFO
o_tx_push  out  1  one-cycle push strobe
i_tx_full  in  1  core TX FIFO full
i_rx_popdata  in  8  core RX FIFO head byte (show-ahead)
i_rx_valid  in  1  core RX FIFO not empty
o_rx_pop  out  1  one-cycle pop strobe
o_irq  out  1  RX interrupt, level

Behaviour:
- Reset: clk single clock domain; rst asynchronous active-high. While rst is high, every output is 0: PRDATA, PREADY, PSLVERR, o_tx_pushdata, o_tx_push, o_rx_pop and o_irq. The control register is 0, the drop counter is 0 and the FSM is in IDLE.
- If rst asserts mid-transfer, the FSM returns to IDLE and any pending strobe is cancelled. The master must restart the transfer.
- FSM states: IDLE and RESP.
  - IDLE: PREADY=0. When PSEL=1 and PENABLE=1, the block registers the decode result and moves to RESP.
  - RESP: PREADY=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
  - Every transfer therefore has exactly one wait state. PREADY is low in the first access cycle and high in the second.
- PRDATA and PSLVERR are registered on the IDLE->RESP edge and are held only during RESP. Outside RESP both are 0.
- Register map (PADDR[3:2]):
  - 0x0 STATUS, read-only: [0]=i_rx_valid, [1]=i_tx_full, [2]=drop_sticky, [15:8]=drop_cnt, all other bits 0.
  - 0x4 TXDATA, write-only. Write with i_tx_full=0: o_tx_pushdata=PWDATA[7:0] and o_tx_push=1 during the RESP cycle. Write with i_tx_full=1 (sampled at the IDLE->RESP edge): no push, drop_sticky is set, and drop_cnt is incremented, saturating at 255.
  - 0x8 RXDATA, read-only. Read with i_rx_valid=1: PRDATA={24'b0, i_rx_popdata}, captured before the pop, and o_rx_pop=1 during the RESP cycle. Read with i_rx_valid=0: PRDATA=0, no pop, PSLVERR=0.
  - 0xC CTRL, read/write. [0]=rx_irq_en, stored. [1]=clr, write-1: clears drop_sticky and drop_cnt in the RESP cycle. clr is not stored and reads back as 0.
- PSLVERR=1 with no side effects for: a read of TXDATA, a write to STATUS, or a write to RXDATA.
- o_tx_pushdata holds its last value between pushes.
- If a TX drop and a clr would take effect in the same cycle, the clr wins.
- o_irq = rx_irq_en & i_rx_valid, registered, so it lags by one cycle.
- A pop or push is issued at most once per APB transfer, even if the master holds PSEL/PENABLE high through RESP. A new transfer requires passing through IDLE.

Decomposition:
- Package uart_apb_pkg: register offset localparams (STATUS=2'd0, TXDATA=2'd1, RXDATA=2'd2, CTRL=2'd3), the CTRL and STATUS bit index constants, and the typedef enum logic {IDLE, RESP} apb_state_e.
- No sub-module; the FSM, decode and counter stay in one module. The top-level wrapper instantiates apb_uart_if next to uart_top.

Test Plan:
- Reset check: hold rst for 3 cycles mid-transfer -> all outputs 0, then read STATUS -> PRDATA=0x0000_0000 with PREADY high exactly 1 cycle after PENABLE.
- TX push: write 0x41 to 0x4 with i_tx_full=0 -> o_tx_push high for 1 cycle with o_tx_pushdata=0x41 in the PREADY cycle, and PSLVERR=0.
- TX drop: with i_tx_full=1, write to 0x4 300 times -> no o_tx_push pulses; STATUS reads [2]=1 and [15:8]=0xFF. Then write CTRL=0x2 -> STATUS reads 0x0000_0002 (the [1]=tx_full bit), with drop fields cleared.
- RX pop: with i_rx_valid=1 and i_rx_popdata=0x5A, read 0x8 -> PRDATA=0x5A and o_rx_pop for 1 cycle. With i_rx_valid=0, read 0x8 -> PRDATA=0 and no pop.
- IRQ: write CTRL=0x1, then raise i_rx_valid -> o_irq rises 1 cycle later. Drop i_rx_valid -> o_irq falls 1 cycle later.
- Errors: read 0x4, write 0x0 and write 0x8 -> PSLVERR=1 each time, with no push/pop and no register change.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared constants for the APB front end of the UART: register offsets,
// bit positions inside STATUS/CTRL and the bus FSM state type.
package uart_apb_pkg;

  localparam logic [1:0] STATUS = 2'd0;
  localparam logic [1:0] TXDATA = 2'd1;
  localparam logic [1:0] RXDATA = 2'd2;
  localparam logic [1:0] CTRL   = 2'd3;

  localparam int ST_RX_VALID     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_DROP_STICKY  = 2;
  localparam int ST_DROP_CNT_LSB = 8;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_CLR       = 1;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  typedef enum logic {IDLE, RESP} apb_state_e;

endpackage

// File: rtl/apb_uart_if.sv
// APB3 slave bridging CPU register accesses to the UART core FIFO port:
// one wait state per transfer, single-cycle push/pop strobes, TX drop counter.
module apb_uart_if
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [7:0]        o_tx_pushdata,
  output logic              o_tx_push,
  input  logic              i_tx_full,
  input  logic [7:0]        i_rx_popdata,
  input  logic              i_rx_valid,
  output logic              o_rx_pop,
  output logic              o_irq
);

  apb_state_e        state_q;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic              pready_q;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic [7:0]        pushdata_q;
  logic [7:0]        drop_cnt_q;
  logic              drop_sticky_q;
  logic              rx_irq_en_q;
  logic              irq_q;
  logic              armed_q;
  logic              access;
  logic              drop_d, clr_d, irq_en_we;
  logic [1:0]        reg_sel;
  logic [15:0]       status_w;
  logic              unused_bits;

  // Only PADDR[3:2], PWDATA[7:0] and the CTRL bits are decoded.
  assign unused_bits = ^{PADDR, PWDATA};

  // armed_q blocks a second access when the master keeps PSEL/PENABLE high past RESP.
  assign access  = (state_q == IDLE) && PSEL && PENABLE && armed_q;
  assign reg_sel = PADDR[3:2];

  always_comb begin
    status_w                           = '0;
    status_w[ST_RX_VALID]              = i_rx_valid;
    status_w[ST_TX_FULL]               = i_tx_full;
    status_w[ST_DROP_STICKY]           = drop_sticky_q;
    status_w[ST_DROP_CNT_LSB +: 8]     = drop_cnt_q;

    prdata_d  = '0;
    pslverr_d = 1'b0;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    drop_d    = 1'b0;
    clr_d     = 1'b0;
    irq_en_we = 1'b0;

    case (reg_sel)
      STATUS: begin
        if (PWRITE) pslverr_d = 1'b1;
        else        prdata_d  = DATA_W'(status_w);
      end
      TXDATA: begin
        if (!PWRITE)        pslverr_d = 1'b1;
        else if (i_tx_full) drop_d    = 1'b1;
        else                push_d    = 1'b1;
      end
      RXDATA: begin
        if (PWRITE) begin
          pslverr_d = 1'b1;
        end else if (i_rx_valid) begin
          prdata_d = DATA_W'(i_rx_popdata);
          pop_d    = 1'b1;
        end
      end
      CTRL: begin
        if (PWRITE) begin
          irq_en_we = 1'b1;
          clr_d     = PWDATA[CTRL_CLR];
        end else begin
          prdata_d = DATA_W'(rx_irq_en_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prdata_q      <= '0;
      pslverr_q     <= 1'b0;
      pready_q      <= 1'b0;
      push_q        <= 1'b0;
      pop_q         <= 1'b0;
      pushdata_q    <= '0;
      drop_cnt_q    <= '0;
      drop_sticky_q <= 1'b0;
      rx_irq_en_q   <= 1'b0;
      irq_q         <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      irq_q <= rx_irq_en_q & i_rx_valid;
      if ((state_q == IDLE) && !PENABLE) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (access) begin
            state_q   <= RESP;
            armed_q   <= 1'b0;
            pready_q  <= 1'b1;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            push_q    <= push_d;
            pop_q     <= pop_d;
            if (push_d)    pushdata_q  <= PWDATA[7:0];
            if (irq_en_we) rx_irq_en_q <= PWDATA[CTRL_RX_IRQ_EN];
            // Clear has priority over a coincident drop.
            if (clr_d) begin
              drop_cnt_q    <= '0;
              drop_sticky_q <= 1'b0;
            end else if (drop_d) begin
              drop_sticky_q <= 1'b1;
              if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
          end
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
          push_q    <= 1'b0;
          pop_q     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PRDATA        = prdata_q;
  assign PREADY        = pready_q;
  assign PSLVERR       = pslverr_q;
  assign o_tx_pushdata = pushdata_q;
  assign o_tx_push     = push_q;
  assign o_rx_pop      = pop_q;
  assign o_irq         = irq_q;

endmodule

// File: tb/tb_apb_uart_if.sv
// Self-checking bench for apb_uart_if: directed scenarios plus randomized
// transfers compared against a register-level reference model.
module tb_apb_uart_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  o_tx_pushdata;
  logic        o_tx_push;
  logic        i_tx_full = 1'b0;
  logic [7:0]  i_rx_popdata = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_pop;
  logic        o_irq;

  int errors = 0;
  int checks = 0;

  int push_cnt = 0;
  int pop_cnt = 0;
  int rdy_cnt = 0;
  logic [7:0] push_byte = '0;

  // Reference model state
  int         m_cnt = 0;
  bit         m_sticky = 0;
  bit         m_en = 0;
  logic [7:0] m_last_push = '0;

  apb_uart_if #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .o_tx_pushdata(o_tx_pushdata), .o_tx_push(o_tx_push), .i_tx_full(i_tx_full),
    .i_rx_popdata(i_rx_popdata), .i_rx_valid(i_rx_valid), .o_rx_pop(o_rx_pop),
    .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_tx_push) begin
        push_cnt++;
        push_byte = o_tx_pushdata;
      end
      if (o_rx_pop) pop_cnt++;
      if (PREADY) rdy_cnt++;
    end
  end

  function automatic void model_reset();
    m_cnt = 0; m_sticky = 0; m_en = 0; m_last_push = '0;
  endfunction

  function automatic void model_xfer(input logic wr, input logic [3:0] addr,
                                     input logic [31:0] wd, input logic txf,
                                     input logic rxv, input logic [7:0] pd,
                                     output logic [31:0] erd, output logic eerr,
                                     output int epush, output int epop);
    int idx;
    idx = int'(addr) / 4;
    erd = '0; eerr = 1'b0; epush = 0; epop = 0;
    if (idx == 0) begin
      if (wr) eerr = 1'b1;
      else erd = 32'(rxv) + 32'(txf) * 2 + 32'(m_sticky) * 4 + 32'(m_cnt) * 256;
    end else if (idx == 1) begin
      if (!wr) eerr = 1'b1;
      else if (txf) begin
        m_sticky = 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        epush = 1;
        m_last_push = wd[7:0];
      end
    end else if (idx == 2) begin
      if (wr) eerr = 1'b1;
      else if (rxv) begin
        erd = 32'(pd);
        epop = 1;
      end
    end else begin
      if (wr) begin
        m_en = wd[0];
        if (wd[1]) begin
          m_cnt = 0;
          m_sticky = 0;
        end
      end else erd = 32'(m_en);
    end
  endfunction

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waitc,
                          output int npush, output int npop, output int nrdy);
    int p0, q0, r0;
    p0 = push_cnt; q0 = pop_cnt; r0 = rdy_cnt;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    waitc = 0;
    while (PREADY !== 1'b1 && waitc < 8) begin
      @(posedge clk); #1;
      waitc++;
    end
    rd = PRDATA;
    err = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    npush = push_cnt - p0;
    npop = pop_cnt - q0;
    nrdy = rdy_cnt - r0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int w, np, nq, nr, p0;
    logic [31:0] mrd; logic merr; int mp, mq;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    p0 = push_cnt;
    @(posedge clk); #1;
    PSEL = 1'b1; PADDR = 4'h4; PWRITE = 1'b1; PWDATA = 32'h77;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({PRDATA, PREADY, PSLVERR, o_tx_pushdata, o_tx_push, o_rx_pop, o_irq} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs_now: got %h want 0",
               {PRDATA, PREADY, PSLVERR, o_tx_pushdata, o_tx_push, o_rx_pop, o_irq});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({PRDATA, PREADY, PSLVERR, o_tx_pushdata, o_tx_push, o_rx_pop, o_irq} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs_held: got %h want 0",
               {PRDATA, PREADY, PSLVERR, o_tx_pushdata, o_tx_push, o_rx_pop, o_irq});
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    rst = 1'b0;
    model_reset();
    model_xfer(1'b0, 4'h0, 32'h0, i_tx_full, i_rx_valid, i_rx_popdata, mrd, merr, mp, mq);
    apb_xfer(1'b0, 4'h0, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (push_cnt - p0 !== 0) begin
      errors++;
      $display("FAIL reset_cancel_push: got %0d pushes want 0", push_cnt - p0);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_status_read: got %h want 00000000", rd);
    end
    checks++;
    if (w !== 1 || nr !== 1) begin
      errors++;
      $display("FAIL reset_pready_timing: got wait=%0d ready_cycles=%0d want 1/1", w, nr);
    end
  endtask

  task automatic test_tx_push();
    logic [31:0] rd, mrd; logic err, merr; int w, np, nq, nr, mp, mq;
    i_tx_full = 1'b0;
    model_xfer(1'b1, 4'h4, 32'h41, 1'b0, i_rx_valid, i_rx_popdata, mrd, merr, mp, mq);
    apb_xfer(1'b1, 4'h4, 32'h41, rd, err, w, np, nq, nr);
    checks++;
    if (np !== 1 || push_byte !== 8'h41) begin
      errors++;
      $display("FAIL tx_push: got pushes=%0d byte=%h want 1/41", np, push_byte);
    end
    checks++;
    if (err !== 1'b0 || w !== 1) begin
      errors++;
      $display("FAIL tx_push_resp: got slverr=%b wait=%0d want 0/1", err, w);
    end
    checks++;
    if (o_tx_pushdata !== 8'h41) begin
      errors++;
      $display("FAIL tx_pushdata_hold: got %h want 41", o_tx_pushdata);
    end
  endtask

  task automatic test_tx_drop();
    logic [31:0] rd, mrd; logic err, merr; int w, np, nq, nr, mp, mq, tot;
    i_tx_full = 1'b1;
    tot = 0;
    for (int i = 0; i < 300; i++) begin
      model_xfer(1'b1, 4'h4, 32'(i), 1'b1, i_rx_valid, i_rx_popdata, mrd, merr, mp, mq);
      apb_xfer(1'b1, 4'h4, 32'(i), rd, err, w, np, nq, nr);
      tot += np;
    end
    checks++;
    if (tot !== 0) begin
      errors++;
      $display("FAIL tx_drop_no_push: got %0d pushes want 0", tot);
    end
    model_xfer(1'b0, 4'h0, 32'h0, 1'b1, i_rx_valid, i_rx_popdata, mrd, merr, mp, mq);
    apb_xfer(1'b0, 4'h0, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (rd !== 32'h0000_FF06) begin
      errors++;
      $display("FAIL tx_drop_status: got %h want 0000ff06", rd);
    end
    model_xfer(1'b1, 4'hC, 32'h2, 1'b1, i_rx_valid, i_rx_popdata, mrd, merr, mp, mq);
    apb_xfer(1'b1, 4'hC, 32'h2, rd, err, w, np, nq, nr);
    model_xfer(1'b0, 4'h0, 32'h0, 1'b1, i_rx_valid, i_rx_popdata, mrd, merr, mp, mq);
    apb_xfer(1'b0, 4'h0, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL tx_drop_clear: got %h want 00000002", rd);
    end
    i_tx_full = 1'b0;
  endtask

  task automatic test_rx_pop();
    logic [31:0] rd, mrd; logic err, merr; int w, np, nq, nr, mp, mq;
    i_rx_valid = 1'b1; i_rx_popdata = 8'h5A;
    model_xfer(1'b0, 4'h8, 32'h0, i_tx_full, 1'b1, 8'h5A, mrd, merr, mp, mq);
    apb_xfer(1'b0, 4'h8, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (rd !== 32'h5A || nq !== 1) begin
      errors++;
      $display("FAIL rx_pop: got data=%h pops=%0d want 0000005a/1", rd, nq);
    end
    i_rx_valid = 1'b0;
    model_xfer(1'b0, 4'h8, 32'h0, i_tx_full, 1'b0, 8'h5A, mrd, merr, mp, mq);
    apb_xfer(1'b0, 4'h8, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (rd !== 32'h0 || nq !== 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rx_empty: got data=%h pops=%0d slverr=%b want 0/0/0", rd, nq, err);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd, mrd; logic err, merr; int w, np, nq, nr, mp, mq;
    i_rx_valid = 1'b0;
    model_xfer(1'b1, 4'hC, 32'h1, i_tx_full, 1'b0, i_rx_popdata, mrd, merr, mp, mq);
    apb_xfer(1'b1, 4'hC, 32'h1, rd, err, w, np, nq, nr);
    @(posedge clk); #1;
    i_rx_valid = 1'b1;
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_lag_rise: got %b want 0", o_irq);
    end
    @(posedge clk); #1;
    checks++;
    if (o_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: got %b want 1", o_irq);
    end
    i_rx_valid = 1'b0;
    checks++;
    if (o_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_lag_fall: got %b want 1", o_irq);
    end
    @(posedge clk); #1;
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall: got %b want 0", o_irq);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, mrd; logic err, merr; int w, np, nq, nr, mp, mq;
    i_tx_full = 1'b0; i_rx_valid = 1'b1; i_rx_popdata = 8'h33;
    apb_xfer(1'b0, 4'h4, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (err !== 1'b1 || np !== 0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_read_tx: got slverr=%b pushes=%0d data=%h want 1/0/0", err, np, rd);
    end
    apb_xfer(1'b1, 4'h0, 32'hFFFF_FFFF, rd, err, w, np, nq, nr);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_write_status: got slverr=%b want 1", err);
    end
    apb_xfer(1'b1, 4'h8, 32'hFFFF_FFFF, rd, err, w, np, nq, nr);
    checks++;
    if (err !== 1'b1 || nq !== 0) begin
      errors++;
      $display("FAIL err_write_rx: got slverr=%b pops=%0d want 1/0", err, nq);
    end
    model_xfer(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 8'h33, mrd, merr, mp, mq);
    apb_xfer(1'b0, 4'h0, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (rd !== mrd) begin
      errors++;
      $display("FAIL err_status_unchanged: got %h want %h", rd, mrd);
    end
    model_xfer(1'b0, 4'hC, 32'h0, 1'b0, 1'b1, 8'h33, mrd, merr, mp, mq);
    apb_xfer(1'b0, 4'hC, 32'h0, rd, err, w, np, nq, nr);
    checks++;
    if (rd !== mrd) begin
      errors++;
      $display("FAIL err_ctrl_unchanged: got %h want %h", rd, mrd);
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic test_held_select();
    int p0, r0;
    i_tx_full = 1'b0;
    p0 = push_cnt; r0 = rdy_cnt;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 4'h4; PWRITE = 1'b1; PWDATA = 32'hC3;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    m_last_push = 8'hC3;
    checks++;
    if (push_cnt - p0 !== 1 || rdy_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL held_select: got pushes=%0d ready_cycles=%0d want 1/1",
               push_cnt - p0, rdy_cnt - r0);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, wd; logic err, merr, wr; logic [3:0] addr;
    int w, np, nq, nr, mp, mq, bad;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (addr[3:2] == 2'd3 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
      i_tx_full = ($urandom_range(0, 2) == 0);
      i_rx_valid = 1'($urandom_range(0, 1));
      i_rx_popdata = 8'($urandom);
      model_xfer(wr, addr, wd, i_tx_full, i_rx_valid, i_rx_popdata, mrd, merr, mp, mq);
      apb_xfer(wr, addr, wd, rd, err, w, np, nq, nr);
      bad = 0;
      if (rd !== mrd || err !== merr || np !== mp || nq !== mq || w !== 1 || nr !== 1) bad = 1;
      if (o_tx_pushdata !== m_last_push || o_irq !== (m_en & i_rx_valid)) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_%0d: got rd=%h err=%b push=%0d pop=%0d wait=%0d rdy=%0d pd=%h irq=%b want rd=%h err=%b push=%0d pop=%0d wait=1 rdy=1 pd=%h irq=%b",
                 i, rd, err, np, nq, w, nr, o_tx_pushdata, o_irq,
                 mrd, merr, mp, mq, m_last_push, m_en & i_rx_valid);
      end
    end
    i_tx_full = 1'b0; i_rx_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_push();
    test_tx_drop();
    test_rx_pop();
    test_irq();
    test_errors();
    test_held_select();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
